// File: rtl/frame_tx_11.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_11
//  Description : Serial frame transmitter for the "11"-marker link. Accepts
//                a parallel word over valid/ready and sends it MSB first,
//                one bit per clock: sync marker "110", then the payload with
//                a 0 stuffed after every payload 1, then IDLE_GAP forced 0s.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_11 #(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             frame_done
);

    localparam int c_BIT_W = $clog2(WIDTH + 1);
    localparam int c_GAP_W = $clog2(IDLE_GAP + 1);

    localparam logic [c_BIT_W-1:0] c_BITCNT_INIT = c_BIT_W'(WIDTH);
    localparam logic [c_BIT_W-1:0] c_BITCNT_ONE  = c_BIT_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST    = c_GAP_W'(IDLE_GAP - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE     = c_GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC1 = 3'd1,
        S_SYNC2 = 3'd2,
        S_SEP   = 3'd3,
        S_DATA  = 3'd4,
        S_STUFF = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [c_BIT_W-1:0] r_bitcnt;
    logic [c_BIT_W-1:0] w_bitcnt_nxt;
    logic [c_BIT_W-1:0] w_bitcnt_dec;
    logic [c_GAP_W-1:0] r_gapcnt;
    logic [c_GAP_W-1:0] w_gapcnt_nxt;

    assign w_bitcnt_dec = r_bitcnt - c_BITCNT_ONE;

    // State, shift register and counters; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
        end
    end

    // Next-state/datapath and output decode; outputs depend only on registers.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        din_ready    = 1'b0;
        busy         = 1'b1;
        sout         = 1'b0;
        sout_en      = 1'b0;
        frame_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                if (din_valid) begin
                    w_state_nxt  = S_SYNC1;
                    w_shreg_nxt  = din;
                    w_bitcnt_nxt = c_BITCNT_INIT;
                end
            end
            S_SYNC1: begin
                sout        = 1'b1;
                sout_en     = 1'b1;
                w_state_nxt = S_SYNC2;
            end
            S_SYNC2: begin
                sout        = 1'b1;
                sout_en     = 1'b1;
                w_state_nxt = S_SEP;
            end
            S_SEP: begin
                sout_en     = 1'b1;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                sout         = r_shreg[WIDTH-1];
                sout_en      = 1'b1;
                w_shreg_nxt  = r_shreg << 1;
                w_bitcnt_nxt = w_bitcnt_dec;
                // A payload 1 is always followed by a stuff 0, even the last bit.
                if (r_shreg[WIDTH-1]) begin
                    w_state_nxt = S_STUFF;
                end else if (w_bitcnt_dec == '0) begin
                    w_state_nxt  = S_GAP;
                    w_gapcnt_nxt = '0;
                end
            end
            S_STUFF: begin
                sout_en = 1'b1;
                if (r_bitcnt == '0) begin
                    w_state_nxt  = S_GAP;
                    w_gapcnt_nxt = '0;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_GAP: begin
                if (r_gapcnt == c_GAP_LAST) begin
                    frame_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gapcnt_nxt = r_gapcnt + c_GAP_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
